// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types and constants for the AES MixColumns datapath.
//                Holds the 128-bit state and 32-bit column types, the
//                control FSM encoding, the GF(2^8) reduction constant and
//                the MixColumns / InvMixColumns coefficient bytes.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    // Low byte of x^8 + x^4 + x^3 + x + 1, folded in when xtime overflows.
    localparam logic [7:0] GF_POLY = 8'h1b;

    // Forward MixColumns coefficients.
    localparam logic [7:0] FWD_F2 = 8'h02;
    localparam logic [7:0] FWD_F3 = 8'h03;

    // Inverse MixColumns coefficients.
    localparam logic [7:0] INV_FE = 8'h0e;
    localparam logic [7:0] INV_FB = 8'h0b;
    localparam logic [7:0] INV_FD = 8'h0d;
    localparam logic [7:0] INV_F9 = 8'h09;

endpackage
`default_nettype wire

// File: rtl/MultiplierGF.sv
`default_nettype none
// ============================================================================
//  Module      : MultiplierGF
//  Description : Combinational GF(2^8) multiply by a constant FACTOR, modulo
//                x^8 + x^4 + x^3 + x + 1. With FACTOR fixed at elaboration
//                the shift/XOR chain reduces to a small XOR network.
//  Ports       : a_i  [7:0] in   operand byte
//                p_o  [7:0] out  a_i * FACTOR
//  Revision    : 1.0  initial release
// ============================================================================
module MultiplierGF
    import aes_pkg::*;
#(
    parameter logic [7:0] FACTOR = 8'h02
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);

    logic [7:0] w_acc;
    logic [7:0] w_pow;

    // Shift-and-add: w_pow walks a, 2a, 4a, ... and each set bit of FACTOR
    // folds the matching power into the product.
    always_comb begin
        w_acc = 8'h00;
        w_pow = a_i;
        for (int k = 0; k < 8; k++) begin
            if (FACTOR[k]) begin
                w_acc = w_acc ^ w_pow;
            end
            w_pow = {w_pow[6:0], 1'b0} ^ (w_pow[7] ? GF_POLY : 8'h00);
        end
        p_o = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/mix_column_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mix_column_unit
//  Description : Combinational MixColumns / InvMixColumns on one 32-bit
//                column. Byte 0 of the column sits in [31:24].
//  Ports       : col_i  [31:0] in   input column
//                inv_i         in   0 = forward, 1 = inverse
//                col_o  [31:0] out  mixed column
//  Revision    : 1.0  initial release
// ============================================================================
module mix_column_unit
    import aes_pkg::*;
(
    input  col_t col_i,
    input  logic inv_i,
    output col_t col_o
);

    logic [7:0] w_a  [4];
    logic [7:0] w_m2 [4];
    logic [7:0] w_m3 [4];
    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];
    logic [7:0] w_fwd[4];
    logic [7:0] w_inv[4];

    // Every product each row needs, one set per input byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign w_a[gi] = col_i[31-8*gi -: 8];

            MultiplierGF #(.FACTOR(FWD_F2)) u_m2 (.a_i(w_a[gi]), .p_o(w_m2[gi]));
            MultiplierGF #(.FACTOR(FWD_F3)) u_m3 (.a_i(w_a[gi]), .p_o(w_m3[gi]));
            MultiplierGF #(.FACTOR(INV_F9)) u_m9 (.a_i(w_a[gi]), .p_o(w_m9[gi]));
            MultiplierGF #(.FACTOR(INV_FB)) u_mb (.a_i(w_a[gi]), .p_o(w_mb[gi]));
            MultiplierGF #(.FACTOR(INV_FD)) u_md (.a_i(w_a[gi]), .p_o(w_md[gi]));
            MultiplierGF #(.FACTOR(INV_FE)) u_me (.a_i(w_a[gi]), .p_o(w_me[gi]));
        end
    endgenerate

    // Row r uses the circulant matrix rotated by r positions.
    generate
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            assign w_fwd[gr] = w_m2[gr] ^ w_m3[(gr+1)%4] ^ w_a[(gr+2)%4] ^ w_a[(gr+3)%4];
            assign w_inv[gr] = w_me[gr] ^ w_mb[(gr+1)%4] ^ w_md[(gr+2)%4] ^ w_m9[(gr+3)%4];
            assign col_o[31-8*gr -: 8] = inv_i ? w_inv[gr] : w_fwd[gr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_seq
//  Description : AES MixColumns / InvMixColumns stage with valid/ready
//                handshakes on both sides. Default build processes one
//                column per clock through a shared mix_column_unit (4-cycle
//                BUSY). Defining MIXCOL_PARALLEL_EN instantiates four units
//                and finishes the whole state in a single BUSY cycle.
//  Ports       : clk            in   rising-edge clock
//                rst_n          in   asynchronous active-low reset
//                in_valid       in   upstream state valid
//                in_ready       out  block can accept a state
//                inv            in   0 = MixColumns, 1 = InvMixColumns
//                stateIn  [127:0] in   input state, byte 0 in [127:120]
//                out_valid      out  stateOut holds a complete result
//                out_ready      in   downstream accepts the result
//                stateOut [127:0] out result state
//  Macro       : MIXCOL_PARALLEL_EN (optional, four parallel column units)
//  Revision    : 1.0  initial release
// ============================================================================
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] stateIn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] stateOut
);

    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    fsm_e        state_q, state_d;
    logic [1:0]  col_q, col_d;
    state_t      work_q, work_d;
    logic        inv_q, inv_d;
    state_t      out_q, out_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    state_t      w_mixed;

    assign w_accept = in_valid && in_ready_q;
    assign w_xfer   = out_valid_q && out_ready;

`ifdef MIXCOL_PARALLEL_EN
    // All columns mixed in one pass; the single BUSY cycle is always last.
    generate
        for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
            mix_column_unit u_mcu (
                .col_i (work_q[127-32*gc -: 32]),
                .inv_i (inv_q),
                .col_o (w_mixed[127-32*gc -: 32])
            );
        end
    endgenerate

    assign w_last = 1'b1;
`else
    col_t w_col_in;
    col_t w_col_out;

    always_comb begin
        w_col_in = work_q[127:96];
        case (col_q)
            2'd0:    w_col_in = work_q[127:96];
            2'd1:    w_col_in = work_q[95:64];
            2'd2:    w_col_in = work_q[63:32];
            default: w_col_in = work_q[31:0];
        endcase
    end

    mix_column_unit u_mcu (
        .col_i (w_col_in),
        .inv_i (inv_q),
        .col_o (w_col_out)
    );

    // Working register with only the current column replaced.
    always_comb begin
        w_mixed = work_q;
        case (col_q)
            2'd0:    w_mixed[127:96] = w_col_out;
            2'd1:    w_mixed[95:64]  = w_col_out;
            2'd2:    w_mixed[63:32]  = w_col_out;
            default: w_mixed[31:0]   = w_col_out;
        endcase
    end

    assign w_last = (col_q == LAST_COL);
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        inv_d   = inv_q;
        out_d   = out_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    work_d  = stateIn;
                    inv_d   = inv;
                    col_d   = 2'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                work_d = w_mixed;
                col_d  = col_q + 2'd1;
                if (w_last) begin
                    // Publish the finished state, including the column
                    // completed on this very edge.
                    out_d   = w_mixed;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (w_xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are registered from the next state so that
        // in_ready stays low for the first edge out of reset.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            inv_q       <= 1'b0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            inv_q       <= inv_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign stateOut  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_columns_seq
//  Description : Self-checking bench for mix_columns_seq. Directed FIPS-197
//                vectors, back-pressure, mid-operation reset and a random
//                back-to-back stream against an independent xtime model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mix_columns_seq;

`ifdef MIXCOL_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif
    localparam int N_STREAM = 1000;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         inv       = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] stateIn   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] stateOut;

    int n_checks = 0;
    int n_fail   = 0;

    mix_columns_seq #(.NUM_COLS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inv       (inv),
        .stateIn   (stateIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stateOut  (stateOut)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (xtime formulation) -----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, t;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        t  = a0 ^ a1 ^ a2 ^ a3;
        ref_fwd = {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2),
                   a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
    endfunction

    // InvMixColumns = MixColumns after a cheap pre-conditioning step.
    function automatic logic [31:0] ref_inv(input logic [31:0] c);
        logic [7:0] u, v;
        u = xt(xt(c[31:24] ^ c[15:8]));
        v = xt(xt(c[23:16] ^ c[7:0]));
        ref_inv = ref_fwd({c[31:24] ^ u, c[23:16] ^ v, c[15:8] ^ u, c[7:0] ^ v});
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic i);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = i ? ref_inv(s[127-32*c -: 32]) : ref_fwd(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers (no checking inside) ---------------
    // Presents one state, waits for acceptance, then scrambles the inputs
    // and counts edges until out_valid. lat = 999 on any timeout.
    task automatic send(input logic [127:0] s, input logic i,
                        output int lat, output logic [127:0] res);
        int k;
        stateIn  = s;
        inv      = i;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        res = '0;
        if (!in_ready) begin
            in_valid = 1'b0;
            lat = 999;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        stateIn  = ~s;
        inv      = ~i;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = 999;
        res = stateOut;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        #12;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || stateOut !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b stateOut=%h, required 0 0 0",
                     in_ready, out_valid, stateOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b before first edge, required 0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_edge_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_forward();
        int lat; logic [127:0] res;
        send(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, lat, res);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL fwd_latency: got %0d edges, required %0d", lat, LAT);
        end
        n_checks++;
        if (res !== 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8) begin
            n_fail++;
            $display("FAIL fwd_fips: got %h, required 8e4da1bc9fdc589d010101014d7ebdf8", res);
        end
        take();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_transfer: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_inverse();
        int lat; logic [127:0] res;
        send(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, lat, res);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL inv_latency: got %0d edges, required %0d", lat, LAT);
        end
        n_checks++;
        if (res !== 128'hdb135345_f20a225c_01010101_2d26314c) begin
            n_fail++;
            $display("FAIL inv_fips: got %h, required db135345f20a225c010101012d26314c", res);
        end
        take();
    endtask

    task automatic test_invariant();
        int lat; logic [127:0] res;
        send(128'hc6c6c6c6_d4d4d4d5_01010101_00000000, 1'b0, lat, res);
        n_checks++;
        if (res !== 128'hc6c6c6c6_d5d5d7d6_01010101_00000000) begin
            n_fail++;
            $display("FAIL invariant_cols: got %h, required c6c6c6c6d5d5d7d60101010100000000", res);
        end
        take();
    endtask

    task automatic test_backpressure();
        int lat; logic [127:0] res;
        bit bad;
        send(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, lat, res);
        // A competing input is held the whole time; it must not get in.
        stateIn  = 128'hc6c6c6c6_d4d4d4d5_01010101_00000000;
        inv      = 1'b0;
        in_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                stateOut !== 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b stateOut=%h, required 1 0 8e4da1bc9fdc589d010101014d7ebdf8",
                     out_valid, in_ready, stateOut);
        end
        take();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_transfer: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: in_ready=%b after accept edge, required 0", in_ready);
        end
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 100);
        n_checks++;
        if (stateOut !== 128'hc6c6c6c6_d5d5d7d6_01010101_00000000 || lat !== LAT) begin
            n_fail++;
            $display("FAIL bp_next_result: got %h after %0d edges, required c6c6c6c6d5d5d7d60101010100000000 after %0d",
                     stateOut, lat, LAT);
        end
        take();
    endtask

    task automatic test_reset_mid_busy();
        int lat; logic [127:0] res;
        stateIn  = 128'h01234567_89abcdef_fedcba98_76543210;
        inv      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || stateOut !== 128'h0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: out_valid=%b stateOut=%h in_ready=%b, required 0 0 0",
                     out_valid, stateOut, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        send(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, lat, res);
        n_checks++;
        if (res !== 128'hdb135345_f20a225c_01010101_2d26314c || lat !== LAT) begin
            n_fail++;
            $display("FAIL midreset_fresh: got %h after %0d edges, required db135345f20a225c010101012d26314c after %0d",
                     res, lat, LAT);
        end
        take();
    endtask

    task automatic test_back_to_back();
        logic [127:0] q_exp[$];
        logic [127:0] cur, so, exp_v;
        logic         ci;
        bit           acc, xf;
        int           sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        cur = {$urandom, $urandom, $urandom, $urandom};
        ci  = 1'b0;
        stateIn = cur; inv = ci; in_valid = 1'b1;
        while (got < N_STREAM && cyc < N_STREAM * 20) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            so  = stateOut;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q_exp.push_back(ref_state(cur, ci));
                sent++;
                if (sent < N_STREAM) begin
                    cur = {$urandom, $urandom, $urandom, $urandom};
                    ci  = ~ci;
                    stateIn = cur; inv = ci;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (xf) begin
                got++;
                n_checks++;
                if (q_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: output %0d = %h with no pending input", got, so);
                end else begin
                    exp_v = q_exp.pop_front();
                    if (so !== exp_v) begin
                        n_fail++;
                        $display("FAIL stream_data: output %0d got %h, required %h", got, so, exp_v);
                    end
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (got != N_STREAM || sent != N_STREAM || q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: sent %0d received %0d pending %0d, required %0d %0d 0",
                     sent, got, q_exp.size(), N_STREAM, N_STREAM);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_invariant();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
